// File: rtl/bitfusion_pkg.sv
// Shared definitions for the BitFusion operand feeder: width codes, FSM
// state encoding, the per-beat descriptor and operand slicing helpers.
package bitfusion_pkg;

    // Operand width codes (one-hot).
    localparam logic [2:0] W2 = 3'b001;
    localparam logic [2:0] W4 = 3'b010;
    localparam logic [2:0] W8 = 3'b100;

    // Width of one fusion-unit slice.
    localparam int SLICE_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // Everything the fusion unit sees for one beat, plus the beat index
    // so the feeder knows where to resume the search for the next beat.
    typedef struct packed {
        logic [SLICE_W-1:0] in_slice;
        logic [SLICE_W-1:0] w_slice;
        logic [2:0]         in_wc;
        logic [2:0]         w_wc;
        logic               s_in;
        logic               s_w;
        logic [3:0]         shift;
        logic               last;
        logic [1:0]         idx;
    } beat_t;

    // Number of 4-bit slices an operand of the given width occupies.
    function automatic logic [1:0] slice_count(input logic [2:0] wc);
        return (wc == W8) ? 2'd2 : 2'd1;
    endfunction

    // Only the three one-hot codes are meaningful.
    function automatic logic width_legal(input logic [2:0] wc);
        return (wc == W2) || (wc == W4) || (wc == W8);
    endfunction

    // Selects the high or low nibble of a right-justified 8-bit operand.
    function automatic logic [SLICE_W-1:0] pick_slice(input logic [7:0] v,
                                                      input logic       hi);
        return hi ? v[7:4] : v[3:0];
    endfunction

endpackage

// File: rtl/bitfusion_slice_sel.sv
// Combinational beat selector. Given an operand pair and the lowest beat
// index still eligible, finds the next beat to issue, whether it is the
// final beat of the pair, and the slice/width/sign/shift it carries.
// Optional feature: FEEDER_ZERO_SKIP_EN drops beats with an all-zero slice.
module bitfusion_slice_sel
    import bitfusion_pkg::*;
(
    input  logic [7:0] i_in,
    input  logic [7:0] i_w,
    input  logic [2:0] i_in_wc,
    input  logic [2:0] i_w_wc,
    input  logic       i_s_in,
    input  logic       i_s_w,
    input  logic [2:0] i_start,
    output beat_t      o_beat
);

    logic       w_in8;
    logic       w_w8;
    logic [3:0] w_valid;
    logic       w_found;
    logic [1:0] w_idx;
    logic       w_last;
    logic       w_hi_in;
    logic       w_hi_w;

    assign w_in8 = (slice_count(i_in_wc) == 2'd2);
    assign w_w8  = (slice_count(i_w_wc)  == 2'd2);

    // Mark which of the four beat indices this operand pair actually needs.
    always_comb begin
        // NOTE: every variable written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_valid = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            w_valid[b] = (!b[0] || w_in8) && (!b[1] || w_w8)
`ifdef FEEDER_ZERO_SKIP_EN
                && (pick_slice(i_in, b[0] && w_in8) != 4'h0)
                && (pick_slice(i_w,  b[1] && w_w8)  != 4'h0)
`endif
                ;
        end
    end

    // First needed index at or after i_start; if none exists (all-zero pair
    // with skipping enabled) fall back to beat 0 flagged as last.
    always_comb begin
        w_found = 1'b0;
        w_idx   = 2'd0;
        for (int b = 0; b < 4; b++) begin
            if (!w_found && (3'(b) >= i_start) && w_valid[b]) begin
                w_idx   = 2'(b);
                w_found = 1'b1;
            end
        end
    end

    // The chosen beat is last when no needed index lies beyond it.
    always_comb begin
        w_last = 1'b1;
        for (int b = 0; b < 4; b++) begin
            if ((3'(b) > {1'b0, w_idx}) && w_valid[b]) begin
                w_last = 1'b0;
            end
        end
    end

    assign w_hi_in = w_idx[0] & w_in8;
    assign w_hi_w  = w_idx[1] & w_w8;

    // Build the beat descriptor: 8-bit operands split into 4-bit slices
    // where only the high slice keeps the operand's sign; narrow operands
    // pass their low nibble and own width code through untouched.
    always_comb begin
        o_beat          = '0;
        o_beat.in_slice = pick_slice(i_in, w_hi_in);
        o_beat.w_slice  = pick_slice(i_w,  w_hi_w);
        o_beat.in_wc    = w_in8 ? W4 : i_in_wc;
        o_beat.w_wc     = w_w8  ? W4 : i_w_wc;
        o_beat.s_in     = w_in8 ? (w_hi_in & i_s_in) : i_s_in;
        o_beat.s_w      = w_w8  ? (w_hi_w  & i_s_w)  : i_s_w;
        o_beat.shift    = ({3'b000, w_hi_in} + {3'b000, w_hi_w}) << 2;
        o_beat.last     = w_last;
        o_beat.idx      = w_idx;
    end

endmodule

// File: rtl/bitfusion_feeder.sv
// BitFusion operand feeder: accepts one activation/weight pair at a time
// and streams it to a 4-bit fusion unit as 1, 2 or 4 slice beats with the
// matching partial-sum shift. Back-to-back pairs issue without a gap.
// Optional feature: FEEDER_ZERO_SKIP_EN (handled in bitfusion_slice_sel).
module bitfusion_feeder
    import bitfusion_pkg::*;
#(
    parameter int OPW = 8,
    parameter int SLW = 4
)(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           op_valid,
    output logic           op_ready,
    input  logic [OPW-1:0] op_in,
    input  logic [OPW-1:0] op_weight,
    input  logic [2:0]     op_in_width,
    input  logic [2:0]     op_weight_width,
    input  logic           op_s_in,
    input  logic           op_s_weight,
    output logic           fu_valid,
    input  logic           fu_ready,
    output logic [SLW-1:0] fu_in,
    output logic [SLW-1:0] fu_weight,
    output logic [2:0]     fu_in_width,
    output logic [2:0]     fu_weight_width,
    output logic           fu_s_in,
    output logic           fu_s_weight,
    output logic [3:0]     fu_shift,
    output logic           fu_last,
    output logic           err
);

    state_t     r_state;
    logic [7:0] r_in;
    logic [7:0] r_w;
    logic [2:0] r_in_wc;
    logic [2:0] r_w_wc;
    logic       r_s_in;
    logic       r_s_w;
    logic [1:0] r_beat;
    logic       r_fu_valid;
    beat_t      r_fu_beat;
    logic       r_err;

    logic       w_accept;
    logic       w_legal;
    logic       w_fire;
    logic [7:0] w_sel_in;
    logic [7:0] w_sel_w;
    logic [2:0] w_sel_in_wc;
    logic [2:0] w_sel_w_wc;
    logic       w_sel_s_in;
    logic       w_sel_s_w;
    logic [2:0] w_sel_start;
    beat_t      w_sel;

    // Ready when idle, or when the final beat of the current pair is being
    // taken so the next pair's first beat can follow immediately.
    assign op_ready = (r_state == ST_IDLE) | (r_fu_valid & fu_ready & r_fu_beat.last);
    assign w_accept = op_valid & op_ready;
    assign w_legal  = width_legal(op_in_width) & width_legal(op_weight_width);
    assign w_fire   = r_fu_valid & fu_ready;

    // On accept the selector looks at the incoming pair from beat 0;
    // otherwise it continues the latched pair after the current beat.
    assign w_sel_in    = w_accept ? op_in           : r_in;
    assign w_sel_w     = w_accept ? op_weight       : r_w;
    assign w_sel_in_wc = w_accept ? op_in_width     : r_in_wc;
    assign w_sel_w_wc  = w_accept ? op_weight_width : r_w_wc;
    assign w_sel_s_in  = w_accept ? op_s_in         : r_s_in;
    assign w_sel_s_w   = w_accept ? op_s_weight     : r_s_w;
    assign w_sel_start = w_accept ? 3'd0 : ({1'b0, r_beat} + 3'd1);

    bitfusion_slice_sel u_slice_sel (
        .i_in    (w_sel_in),
        .i_w     (w_sel_w),
        .i_in_wc (w_sel_in_wc),
        .i_w_wc  (w_sel_w_wc),
        .i_s_in  (w_sel_s_in),
        .i_s_w   (w_sel_s_w),
        .i_start (w_sel_start),
        .o_beat  (w_sel)
    );

    // Issue FSM: latches accepted pairs, advances beats on handshake and
    // holds the registered beat steady while the fusion unit stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand latches are a handful of flops, not a memory,
            // so they are reset along with the control state.
            r_state    <= ST_IDLE;
            r_in       <= '0;
            r_w        <= '0;
            r_in_wc    <= '0;
            r_w_wc     <= '0;
            r_s_in     <= 1'b0;
            r_s_w      <= 1'b0;
            r_beat     <= 2'd0;
            r_fu_valid <= 1'b0;
            r_fu_beat  <= '0;
            r_err      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_in       <= op_in;
                            r_w        <= op_weight;
                            r_in_wc    <= op_in_width;
                            r_w_wc     <= op_weight_width;
                            r_s_in     <= op_s_in;
                            r_s_w      <= op_s_weight;
                            r_beat     <= w_sel.idx;
                            r_fu_beat  <= w_sel;
                            r_fu_valid <= 1'b1;
                            r_state    <= ST_ISSUE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_fire) begin
                        if (!r_fu_beat.last) begin
                            r_beat    <= w_sel.idx;
                            r_fu_beat <= w_sel;
                        end else if (w_accept && w_legal) begin
                            r_in       <= op_in;
                            r_w        <= op_weight;
                            r_in_wc    <= op_in_width;
                            r_w_wc     <= op_weight_width;
                            r_s_in     <= op_s_in;
                            r_s_w      <= op_s_weight;
                            r_beat     <= w_sel.idx;
                            r_fu_beat  <= w_sel;
                            r_fu_valid <= 1'b1;
                        end else begin
                            r_err          <= w_accept;
                            r_fu_valid     <= 1'b0;
                            r_fu_beat.last <= 1'b0;
                            r_state        <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign fu_valid        = r_fu_valid;
    assign fu_in           = r_fu_beat.in_slice;
    assign fu_weight       = r_fu_beat.w_slice;
    assign fu_in_width     = r_fu_beat.in_wc;
    assign fu_weight_width = r_fu_beat.w_wc;
    assign fu_s_in         = r_fu_beat.s_in;
    assign fu_s_weight     = r_fu_beat.s_w;
    assign fu_shift        = r_fu_beat.shift;
    assign fu_last         = r_fu_beat.last;
    assign err             = r_err;

endmodule
